// File: rtl/prog_writer_pkg.sv
// prog_writer_pkg
//   Shared CPU constants: front-end operation codes, MIPS opcode/funct
//   values, the program-writer FSM state encoding and small word-building
//   helpers. The decoder and the program writer both import this package
//   so they agree on every encoding.
package prog_writer_pkg;

  // Front-end operation codes carried on in_code
  typedef enum logic [3:0] {
    CODE_SLTU    = 4'd0,
    CODE_SLT     = 4'd1,
    CODE_BGTZ    = 4'd2,
    CODE_BNE     = 4'd3,
    CODE_BEQ     = 4'd4,
    CODE_SW      = 4'd5,
    CODE_LW      = 4'd6,
    CODE_SLL     = 4'd7,
    CODE_OR      = 4'd8,
    CODE_AND     = 4'd9,
    CODE_SUBU    = 4'd10,
    CODE_SUB     = 4'd11,
    CODE_ADDU    = 4'd12,
    CODE_ADDI    = 4'd13,
    CODE_ADD     = 4'd14,
    CODE_ILLEGAL = 4'd15
  } op_code_e;

  // MIPS primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_BGTZ  = 6'h07;

  // MIPS R-type funct values
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // Program-writer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } pw_state_e;

  // Byte address of program word 'count' starting at 'base'
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] count);
    return base + {14'd0, count, 2'b00};
  endfunction

  // R-type word: {op, rs, rt, rd, shamt, funct}
  function automatic logic [31:0] r_type(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd,
                                         input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  // I-type word: {op, rs, rt, imm}
  function automatic logic [31:0] i_type(input logic [5:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/prog_writer_if.sv
// prog_writer_if
//   Bundles the instruction-field handshake (in_*) and the instruction
//   memory write port (mem_*) of the program writer.
//   slave  : the program writer (consumes fields, drives memory writes)
//   master : the environment (supplies fields, acknowledges writes)
interface prog_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_adr;
  logic [31:0] mem_data;

  modport slave (
    input  in_valid, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    output in_ready,
    output mem_we, mem_adr, mem_data,
    input  mem_ready
  );

  modport master (
    output in_valid, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    input  in_ready,
    input  mem_we, mem_adr, mem_data,
    output mem_ready
  );
endinterface

// File: rtl/prog_writer_inst_encode.sv
// inst_encode
//   Purely combinational: maps front-end instruction fields to a 32-bit
//   MIPS instruction word and flags the illegal operation code.
//   Ports: code/rs/rt/rd/shamt/imm in; word (encoded instruction) and
//   illegal (code not encodable) out.
module inst_encode
  import prog_writer_pkg::*;
(
  input  logic [3:0]  code,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Field-to-word mapping; sll ignores rs, other R-types ignore shamt, bgtz ignores rt
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (code)
      CODE_ADD:  word = r_type(rs, rt, rd, 5'd0, FUNCT_ADD);
      CODE_ADDU: word = r_type(rs, rt, rd, 5'd0, FUNCT_ADDU);
      CODE_SUB:  word = r_type(rs, rt, rd, 5'd0, FUNCT_SUB);
      CODE_SUBU: word = r_type(rs, rt, rd, 5'd0, FUNCT_SUBU);
      CODE_AND:  word = r_type(rs, rt, rd, 5'd0, FUNCT_AND);
      CODE_OR:   word = r_type(rs, rt, rd, 5'd0, FUNCT_OR);
      CODE_SLL:  word = r_type(5'd0, rt, rd, shamt, FUNCT_SLL);
      CODE_SLT:  word = r_type(rs, rt, rd, 5'd0, FUNCT_SLT);
      CODE_SLTU: word = r_type(rs, rt, rd, 5'd0, FUNCT_SLTU);
      CODE_ADDI: word = i_type(OPC_ADDI, rs, rt, imm);
      CODE_LW:   word = i_type(OPC_LW, rs, rt, imm);
      CODE_SW:   word = i_type(OPC_SW, rs, rt, imm);
      CODE_BEQ:  word = i_type(OPC_BEQ, rs, rt, imm);
      CODE_BNE:  word = i_type(OPC_BNE, rs, rt, imm);
      CODE_BGTZ: word = i_type(OPC_BGTZ, rs, 5'd0, imm);
      default: begin
        word    = 32'd0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/prog_writer.sv
// prog_writer
//   Loads a program into instruction memory: accepts instruction fields,
//   encodes them, and writes one 32-bit word per accepted instruction at
//   sequential addresses from BASE_ADDR, then releases the CPU.
//   Ports: clk, rst_n (async active-low), start (new load pulse),
//   bus (prog_writer_if.slave: field handshake + memory write port),
//   cpu_run (program may execute), word_count (words written this load),
//   err (sticky: illegal code or capacity overflow).
module prog_writer
  import prog_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  prog_writer_if.slave        bus,
  output logic                cpu_run,
  output logic [15:0]         word_count,
  output logic                err
);

  localparam logic [16:0] MAX_LIMIT = 17'(MAX_WORDS);

  pw_state_e   state_r;
  pw_state_e   state_s;
  logic        pend_r;
  logic        pend_s;
  logic [31:0] mem_adr_r;
  logic [31:0] mem_data_r;
  logic [15:0] wc_r;
  logic [15:0] wc_s;
  logic        err_r;
  logic        cpu_run_r;

  logic [31:0] enc_word_s;
  logic        enc_illegal_s;
  logic        complete_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        full_s;
  logic        drop_s;
  logic        write_s;

  inst_encode u_encode (
    .code    (bus.in_code),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .shamt   (bus.in_shamt),
    .imm     (bus.in_imm),
    .word    (enc_word_s),
    .illegal (enc_illegal_s)
  );

  // Handshake and write-slot bookkeeping; start overrides any acceptance
  always_comb begin
    complete_s = pend_r & bus.mem_ready;
    in_ready_s = (state_r == ST_LOAD) & (~pend_r | bus.mem_ready) & ~start;
    accept_s   = in_ready_s & bus.in_valid;
    // A word still in the output register counts against capacity
    full_s     = (({1'b0, wc_r} + {16'd0, pend_r}) == MAX_LIMIT);
    drop_s     = accept_s & (enc_illegal_s | full_s);
    write_s    = accept_s & ~drop_s;
    if (start) begin
      pend_s = 1'b0;
      wc_s   = 16'd0;
    end else begin
      if (write_s) begin
        pend_s = 1'b1;
      end else if (complete_s) begin
        pend_s = 1'b0;
      end else begin
        pend_s = pend_r;
      end
      if (complete_s) begin
        wc_s = wc_r + 16'd1;
      end else begin
        wc_s = wc_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (start) begin
          state_s = ST_LOAD;
        end else if (accept_s & bus.in_last) begin
          // Skip DRAIN when the final word was dropped and nothing is left to write
          if (pend_s) state_s = ST_DRAIN;
          else        state_s = ST_RUN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (start)        state_s = ST_LOAD;
        else if (!pend_s) state_s = ST_RUN;
        else              state_s = ST_DRAIN;
      end
      ST_RUN: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, output register, counter and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pend_r     <= 1'b0;
      mem_adr_r  <= BASE_ADDR;
      mem_data_r <= 32'd0;
      wc_r       <= 16'd0;
      err_r      <= 1'b0;
      cpu_run_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      pend_r    <= pend_s;
      wc_r      <= wc_s;
      // Address tracks the count so it always names the next (or pending) slot
      mem_adr_r <= word_addr(BASE_ADDR, wc_s);
      cpu_run_r <= (state_s == ST_RUN);
      if (write_s) mem_data_r <= enc_word_s;
      else         mem_data_r <= mem_data_r;
      if (start)       err_r <= 1'b0;
      else if (drop_s) err_r <= 1'b1;
      else             err_r <= err_r;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.mem_we   = pend_r;
  assign bus.mem_adr  = mem_adr_r;
  assign bus.mem_data = mem_data_r;
  assign cpu_run      = cpu_run_r;
  assign word_count   = wc_r;
  assign err          = err_r;

endmodule

// File: tb/tb_prog_writer.sv
// tb_prog_writer
//   Directed self-checking bench for prog_writer: one instance with default
//   parameters and one with BASE_ADDR=0x1000, MAX_WORDS=2.
module tb_prog_writer;
  import prog_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic        cpu_run, cpu_run2;
  logic [15:0] word_count, word_count2;
  logic        err, err2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  prog_writer_if pif ();
  prog_writer_if pif2 ();

  prog_writer #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(pif.slave),
    .cpu_run(cpu_run), .word_count(word_count), .err(err));

  prog_writer #(.BASE_ADDR(32'h0000_1000), .MAX_WORDS(2)) u_cap (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(pif2.slave),
    .cpu_run(cpu_run2), .word_count(word_count2), .err(err2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input logic [3:0] code, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic last);
    pif.in_code = code; pif.in_rs = rs; pif.in_rt = rt; pif.in_rd = rd;
    pif.in_shamt = sh; pif.in_imm = imm; pif.in_last = last; pif.in_valid = 1'b1;
  endtask

  task automatic drive2(input logic [3:0] code, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic last);
    pif2.in_code = code; pif2.in_rs = rs; pif2.in_rt = rt; pif2.in_rd = rd;
    pif2.in_shamt = 5'd0; pif2.in_imm = 16'd0; pif2.in_last = last; pif2.in_valid = 1'b1;
  endtask

  task automatic idle_in();
    pif.in_valid = 1'b0; pif.in_last = 1'b0;
    pif2.in_valid = 1'b0; pif2.in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0);
    drive2(4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle_in();
    pif.mem_ready = 1'b1; pif2.mem_ready = 1'b1;
    step();
    checks++; if (pif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", pif.in_ready); end
    checks++; if (pif.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0b want 0", pif.mem_we); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL rst_cpu_run: got %0b want 0", cpu_run); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
    checks++; if (pif.mem_adr !== 32'h0) begin errors++; $display("FAIL rst_mem_adr: got %h want 0", pif.mem_adr); end
    checks++; if (pif.mem_data !== 32'h0) begin errors++; $display("FAIL rst_mem_data: got %h want 0", pif.mem_data); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
    checks++; if (pif2.mem_adr !== 32'h1000) begin errors++; $display("FAIL rst_base_adr: got %h want 00001000", pif2.mem_adr); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (pif.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b want 0", pif.in_ready); end
  endtask

  task automatic test_add();
    pif.mem_ready = 1'b1;
    do_start();
    #1;
    checks++; if (pif.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready: got %0b want 1", pif.in_ready); end
    drive(CODE_ADD, 5'd1, 5'd2, 5'd3, 5'd9, 16'd0, 1'b0);
    step(); idle_in();
    checks++; if (pif.mem_we !== 1'b1) begin errors++; $display("FAIL add_we: got %0b want 1", pif.mem_we); end
    checks++; if (pif.mem_adr !== 32'h0) begin errors++; $display("FAIL add_adr: got %h want 0", pif.mem_adr); end
    checks++; if (pif.mem_data !== 32'h00221820) begin errors++; $display("FAIL add_data: got %h want 00221820", pif.mem_data); end
    step();
    checks++; if (pif.mem_we !== 1'b0) begin errors++; $display("FAIL add_done_we: got %0b want 0", pif.mem_we); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL add_count: got %0d want 1", word_count); end
    checks++; if (pif.mem_adr !== 32'h4) begin errors++; $display("FAIL add_next_adr: got %h want 4", pif.mem_adr); end
  endtask

  task automatic test_sequence();
    pif.mem_ready = 1'b1;
    do_start();
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL seq_restart_count: got %0d want 0", word_count); end
    drive(CODE_ADDI, 5'd0, 5'd4, 5'd0, 5'd0, 16'hFFFF, 1'b0);
    step();
    checks++; if (pif.mem_data !== 32'h2004FFFF) begin errors++; $display("FAIL seq_addi_data: got %h want 2004ffff", pif.mem_data); end
    checks++; if (pif.mem_adr !== 32'h0) begin errors++; $display("FAIL seq_addi_adr: got %h want 0", pif.mem_adr); end
    drive(CODE_LW, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 1'b1);
    step(); idle_in();
    checks++; if (pif.mem_we !== 1'b1) begin errors++; $display("FAIL seq_lw_we: got %0b want 1", pif.mem_we); end
    checks++; if (pif.mem_data !== 32'h8C850008) begin errors++; $display("FAIL seq_lw_data: got %h want 8c850008", pif.mem_data); end
    checks++; if (pif.mem_adr !== 32'h4) begin errors++; $display("FAIL seq_lw_adr: got %h want 4", pif.mem_adr); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL seq_run_early: got %0b want 0", cpu_run); end
    step();
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL seq_run: got %0b want 1", cpu_run); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL seq_count: got %0d want 2", word_count); end
    checks++; if (pif.mem_we !== 1'b0) begin errors++; $display("FAIL seq_done_we: got %0b want 0", pif.mem_we); end
  endtask

  task automatic test_stall();
    pif.mem_ready = 1'b0;
    do_start();
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL stall_run_fall: got %0b want 0", cpu_run); end
    drive(CODE_SLL, 5'd7, 5'd2, 5'd2, 5'd4, 16'd0, 1'b0);
    step(); idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pif.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, pif.in_ready); end
      checks++; if (pif.mem_we !== 1'b1 || pif.mem_adr !== 32'h0 || pif.mem_data !== 32'h00021100) begin
        errors++; $display("FAIL stall_hold[%0d]: got we=%0b adr=%h data=%h want 1/0/00021100", i, pif.mem_we, pif.mem_adr, pif.mem_data);
      end
      step();
    end
    pif.mem_ready = 1'b1;
    #1;
    checks++; if (pif.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_completing: got %0b want 1", pif.in_ready); end
    step();
    checks++; if (pif.mem_we !== 1'b0) begin errors++; $display("FAIL stall_done_we: got %0b want 0", pif.mem_we); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d want 1", word_count); end
  endtask

  task automatic test_illegal();
    pif.mem_ready = 1'b1;
    do_start();
    drive(CODE_BGTZ, 5'd3, 5'd9, 5'd0, 5'd0, 16'h0010, 1'b0);
    step();
    checks++; if (pif.mem_data !== 32'h1C600010) begin errors++; $display("FAIL ill_bgtz_data: got %h want 1c600010", pif.mem_data); end
    drive(CODE_ILLEGAL, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 1'b0);
    step();
    checks++; if (pif.mem_we !== 1'b0) begin errors++; $display("FAIL ill_no_write: got %0b want 0", pif.mem_we); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err: got %0b want 1", err); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL ill_count: got %0d want 1", word_count); end
    drive(CODE_SUB, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1);
    step(); idle_in();
    checks++; if (pif.mem_we !== 1'b1 || pif.mem_adr !== 32'h4) begin errors++; $display("FAIL ill_next_adr: got we=%0b adr=%h want 1/4", pif.mem_we, pif.mem_adr); end
    checks++; if (pif.mem_data !== 32'h00221822) begin errors++; $display("FAIL ill_sub_data: got %h want 00221822", pif.mem_data); end
    step();
    checks++; if (cpu_run !== 1'b1 || err !== 1'b1 || word_count !== 16'd2) begin
      errors++; $display("FAIL ill_end: got run=%0b err=%0b count=%0d want 1/1/2", cpu_run, err, word_count);
    end
    do_start();
    checks++; if (err !== 1'b0 || word_count !== 16'd0) begin errors++; $display("FAIL ill_restart_clear: got err=%0b count=%0d want 0/0", err, word_count); end
    drive(CODE_ILLEGAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b1);
    step(); idle_in();
    checks++; if (cpu_run !== 1'b1 || err !== 1'b1 || pif.mem_we !== 1'b0) begin
      errors++; $display("FAIL ill_last_direct_run: got run=%0b err=%0b we=%0b want 1/1/0", cpu_run, err, pif.mem_we);
    end
  endtask

  task automatic test_restart();
    pif.mem_ready = 1'b0;
    do_start();
    drive(CODE_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
    step();
    start = 1'b1;
    drive(CODE_OR, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 1'b0);
    #1;
    checks++; if (pif.in_ready !== 1'b0) begin errors++; $display("FAIL restart_in_ready: got %0b want 0", pif.in_ready); end
    step();
    start = 1'b0; idle_in();
    checks++; if (pif.mem_we !== 1'b0 || word_count !== 16'd0) begin
      errors++; $display("FAIL restart_discard: got we=%0b count=%0d want 0/0", pif.mem_we, word_count);
    end
    pif.mem_ready = 1'b1;
    drive(CODE_OR, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 1'b0);
    step(); idle_in();
    checks++; if (pif.mem_we !== 1'b1 || pif.mem_adr !== 32'h0 || pif.mem_data !== 32'h00853025) begin
      errors++; $display("FAIL restart_or: got we=%0b adr=%h data=%h want 1/0/00853025", pif.mem_we, pif.mem_adr, pif.mem_data);
    end
    step();
  endtask

  task automatic test_capacity();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    drive2(CODE_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    step();
    checks++; if (pif2.mem_we !== 1'b1 || pif2.mem_adr !== 32'h1000) begin
      errors++; $display("FAIL cap_w0: got we=%0b adr=%h want 1/00001000", pif2.mem_we, pif2.mem_adr);
    end
    drive2(CODE_SUB, 5'd1, 5'd2, 5'd3, 1'b0);
    step();
    checks++; if (pif2.mem_we !== 1'b1 || pif2.mem_adr !== 32'h1004 || pif2.mem_data !== 32'h00221822) begin
      errors++; $display("FAIL cap_w1: got we=%0b adr=%h data=%h want 1/00001004/00221822", pif2.mem_we, pif2.mem_adr, pif2.mem_data);
    end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL cap_err_early: got %0b want 0", err2); end
    drive2(CODE_OR, 5'd4, 5'd5, 5'd6, 1'b1);
    step(); idle_in();
    checks++; if (pif2.mem_we !== 1'b0) begin errors++; $display("FAIL cap_drop: got we=%0b want 0", pif2.mem_we); end
    checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL cap_err: got %0b want 1", err2); end
    checks++; if (word_count2 !== 16'd2) begin errors++; $display("FAIL cap_count: got %0d want 2", word_count2); end
    checks++; if (cpu_run2 !== 1'b1) begin errors++; $display("FAIL cap_run: got %0b want 1", cpu_run2); end
    step();
    checks++; if (word_count2 !== 16'd2) begin errors++; $display("FAIL cap_count_hold: got %0d want 2", word_count2); end
  endtask

  task automatic test_async_reset();
    pif.mem_ready = 1'b1;
    do_start();
    drive(CODE_ILLEGAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b1);
    step(); idle_in();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL areset_run: got %0b want 0", cpu_run); end
    step();
    rst_n = 1'b1;
    pif.mem_ready = 1'b0;
    do_start();
    drive(CODE_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
    step(); idle_in();
    checks++; if (pif.mem_we !== 1'b1) begin errors++; $display("FAIL areset_pre_we: got %0b want 1", pif.mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pif.mem_we !== 1'b0 || pif.mem_adr !== 32'h0 || pif.mem_data !== 32'h0 || word_count !== 16'd0) begin
      errors++; $display("FAIL areset_bus: got we=%0b adr=%h data=%h count=%0d want 0/0/0/0", pif.mem_we, pif.mem_adr, pif.mem_data, word_count);
    end
    step();
    rst_n = 1'b1;
    pif.mem_ready = 1'b1;
    step();
    #1;
    checks++; if (pif.in_ready !== 1'b0 || cpu_run !== 1'b0 || pif.mem_we !== 1'b0) begin
      errors++; $display("FAIL areset_idle: got ready=%0b run=%0b we=%0b want 0/0/0", pif.in_ready, cpu_run, pif.mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sequence();
    test_stall();
    test_illegal();
    test_restart();
    test_capacity();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
